wdt_rst_req: RTL and testbench
==============================

// Module: wdt_rst_req
// PURPOSE
//  Watchdog timer and reset requester: produces the active-low external reset request that clk_rst
//  synchronises and stretches into the system reset. Sits on the I/O bus as a 4-register device;
//  on watchdog expiry or software request it drives rst_req_n low for PULSE_LEN cycles.
// PARAMETERS
//  PRESCALE   50000  clk cycles per watchdog tick (1 ms at 50 MHz); legal range 1..2^20
//  CNT_W      16     width of timeout/count/warning registers
//  PULSE_LEN  8      cycles rst_req_n is held low; must be >= 4
//  KICK_KEY   32'h5A5A_C3C3  value that must be written to COUNT to kick
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous active-high reset (from clk_rst)
//  stb        in   1   bus strobe, held until wt low
//  we         in   1   write enable
//  addr       in   2   register select (byte address bits 3:2)
//  data_in    in   32  write data
//  data_out   out  32  read data, valid in the cycle wt is low
//  wt         out  1   wait: high in first cycle of an access, low in second (access completes)
//  irq        out  1   warning interrupt = WARN & IEN
//  rst_req_n  out  1   reset request to clk_rst.rst_in_n, active low
// BEHAVIOUR
//  Reset (rst=1, one clk edge): state IDLE, EN=IEN=WARN=0, TIMEOUT=all ones, WARNLVL=0, cnt=0,
//   prescaler=0, rst_req_n=1, irq=0, wt=1, data_out=0.
//  Registers: 0 CTRL {bit3 SWRST wo, bit2 WARN r/w1c, bit1 IEN rw, bit0 EN rw}, other bits read 0;
//   1 TIMEOUT rw [CNT_W-1:0]; 2 COUNT ro cnt, write == KICK_KEY kicks, any other write ignored;
//   3 WARNLVL rw. Write takes effect on the edge ending the wt=0 cycle; read data is registered.
//  Bus: cycle 1 stb=1 -> wt=1; cycle 2 stb=1 -> wt=0; stb dropped -> sequencer restarts at cycle 1.
//  Tick: prescaler counts 0..PRESCALE-1 only in RUN, tick on wrap; cleared on entering RUN and on kick.
//  FSM (states in wdt_defs.v):
//   IDLE : EN written 1 -> RUN, cnt<=TIMEOUT.
//   RUN  : tick & cnt!=0 -> cnt-1; tick & cnt==0 -> PULSE; cnt-1==WARNLVL on a tick -> WARN<=1;
//          EN written 0 -> IDLE (cnt held); kick -> cnt<=TIMEOUT, prescaler<=0 (WARN unaffected).
//   PULSE: rst_req_n=0 for exactly PULSE_LEN cycles (pulse counter), then -> HOLD.
//   HOLD : rst_req_n=1; all bus writes ignored; leave only via rst.
//   Any state except PULSE/HOLD: SWRST write 1 -> PULSE on next edge.
//  rst_req_n is a registered output (glitch-free); low starts the edge after the triggering event.
//  Boundary / simultaneity:
//   - kick and expiring tick same cycle: kick wins, no pulse.
//   - EN<=0 write and expiring tick same cycle: expiry wins (-> PULSE).
//   - SWRST beats everything; SWRST with EN=0 still pulses.
//   - TIMEOUT=0: first tick after entering RUN -> PULSE. WARNLVL>=TIMEOUT: WARN never set.
//   - TIMEOUT written in RUN: affects next kick/enable only, not the running cnt.
//   - WARN w1c and WARN set same cycle: set wins.
//   - rst during PULSE (clk_rst answering the request): pulse aborted, rst_req_n=1 next edge; normal.
//   - cnt never wraps below 0; prescaler wrap at PRESCALE-1 exactly.
// STRUCTURE
//  wdt_defs.v (`include): register offsets, CTRL bit positions, FSM state encodings, KICK_KEY default.
//  Sub-module wdt_prescale (PRESCALE param, clr/en inputs, tick output); rest in wdt_rst_req.
// TESTING  (PRESCALE=4, TIMEOUT=5, WARNLVL=2, PULSE_LEN=8 unless noted)
//  1 EN=1, no kicks -> WARN/irq(IEN=1) after 3rd tick (clk 12 after enable), rst_req_n low
//    on edge after 6th tick, low exactly 8 cycles, then HOLD with rst_req_n=1.
//  2 Kick with KICK_KEY every 16 cycles -> no pulse in 1000 cycles; kick with 32'h0 -> pulse as in 1.
//  3 Kick in same cycle as expiring tick -> cnt=5, rst_req_n stays 1; EN<=0 on that cycle -> pulse.
//  4 Write CTRL=0x8 in IDLE -> rst_req_n low next edge for 8 cycles; writes in HOLD have no effect.
//  5 Closed loop with clk_rst: pulse -> rst asserted within 4 cycles -> rst_req_n=1, all regs at reset.
//  6 Bus: every access wt=1 then 0; read TIMEOUT after reset = 16'hFFFF; WARN w1c clears irq.

Source files
------------

// File: rtl/wdt_rst_req_pkg.sv
// Shared definitions for the watchdog / reset requester.
// Register map, CTRL bit positions, FSM states and default kick key.
package wdt_rst_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } wdt_state_e;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_TIMEOUT = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_WARNLVL = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IEN   = 1;
    localparam int CTRL_WARN  = 2;
    localparam int CTRL_SWRST = 3;

    localparam logic [31:0] KICK_KEY_DEF = 32'h5A5A_C3C3;

endpackage

// File: rtl/wdt_prescale.sv
// Watchdog tick prescaler: counts 0..PRESCALE-1 while en, pulses tick on wrap.
// Ports: clk, rst (sync high), clr (restart at 0, no tick), en, tick.
module wdt_prescale
    import wdt_rst_req_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        tick  = 1'b0;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            if (div_q == LAST) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

endmodule

// File: rtl/wdt_rst_req.sv
// Watchdog timer and reset requester on a 4-register two-cycle I/O bus.
// Ports: clk, rst, stb/we/addr/data_in/data_out/wt bus, irq, rst_req_n.
module wdt_rst_req
    import wdt_rst_req_pkg::*;
#(
    parameter int          PRESCALE  = 50000,
    parameter int          CNT_W     = 16,
    parameter int          PULSE_LEN = 8,
    parameter logic [31:0] KICK_KEY  = KICK_KEY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        wt,
    output logic        irq,
    output logic        rst_req_n
);

    localparam int PCW = $clog2(PULSE_LEN);
    localparam logic [PCW-1:0] PLAST = PCW'(PULSE_LEN - 1);

    wdt_state_e       state_q, state_d;
    logic             phase_q, phase_d;
    logic             en_q, en_d, ien_q, ien_d, warn_q, warn_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic [CNT_W-1:0] warnlvl_q, warnlvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
    logic [PCW-1:0]   pcnt_q, pcnt_d;
    logic             rst_req_n_q, rst_req_n_d;
    logic [31:0]      data_out_q, data_out_d;

    logic wr, rd, wr_ctrl, kick, swrst, en_set, en_clr;
    logic tick, presc_clr;

    // Writes land on the edge ending the wt=0 cycle; HOLD ignores them.
    assign wr      = stb & phase_q & we & (state_q != ST_HOLD);
    assign rd      = stb & ~phase_q & ~we;
    assign wr_ctrl = wr & (addr == REG_CTRL);
    assign kick    = wr & (addr == REG_COUNT) & (data_in == KICK_KEY)
                   & (state_q == ST_RUN);
    assign swrst   = wr_ctrl & data_in[CTRL_SWRST]
                   & ((state_q == ST_IDLE) | (state_q == ST_RUN));
    assign en_set  = wr_ctrl & data_in[CTRL_EN];
    assign en_clr  = wr_ctrl & ~data_in[CTRL_EN];
    assign cnt_dec = cnt_q - CNT_W'(1);

    // A kick clears the prescaler, which also suppresses a coincident tick.
    assign presc_clr = kick | ((state_q == ST_IDLE) & en_set);

    wdt_prescale #(.PRESCALE(PRESCALE)) u_prescale (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (state_q == ST_RUN),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = stb & ~phase_q;
        en_d       = en_q;
        ien_d      = ien_q;
        warn_d     = warn_q;
        timeout_d  = timeout_q;
        warnlvl_d  = warnlvl_q;
        cnt_d      = cnt_q;
        pcnt_d     = '0;
        data_out_d = data_out_q;

        if (rd) begin
            unique case (addr)
                REG_CTRL:    data_out_d = {28'd0, 1'b0, warn_q, ien_q, en_q};
                REG_TIMEOUT: data_out_d = 32'(timeout_q);
                REG_COUNT:   data_out_d = 32'(cnt_q);
                REG_WARNLVL: data_out_d = 32'(warnlvl_q);
            endcase
        end

        if (wr) begin
            unique case (addr)
                REG_CTRL: begin
                    en_d  = data_in[CTRL_EN];
                    ien_d = data_in[CTRL_IEN];
                    if (data_in[CTRL_WARN]) warn_d = 1'b0;
                end
                REG_TIMEOUT: timeout_d = data_in[CNT_W-1:0];
                REG_COUNT:   ;
                REG_WARNLVL: warnlvl_d = data_in[CNT_W-1:0];
            endcase
        end

        unique case (state_q)
            ST_IDLE: begin
                if (swrst) begin
                    state_d = ST_PULSE;
                end else if (en_set) begin
                    state_d = ST_RUN;
                    cnt_d   = timeout_q;
                end
            end
            ST_RUN: begin
                if (swrst || (tick && cnt_q == '0)) begin
                    state_d = ST_PULSE;
                end else begin
                    if (kick) begin
                        cnt_d = timeout_q;
                    end else if (tick) begin
                        cnt_d = cnt_dec;
                        // Set after the w1c above so a same-cycle set wins.
                        if (cnt_dec == warnlvl_q) warn_d = 1'b1;
                    end
                    if (en_clr) state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                pcnt_d = pcnt_q + PCW'(1);
                if (pcnt_q == PLAST) state_d = ST_HOLD;
            end
            ST_HOLD: ;
        endcase

        rst_req_n_d = (state_d != ST_PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            en_q        <= 1'b0;
            ien_q       <= 1'b0;
            warn_q      <= 1'b0;
            timeout_q   <= '1;
            warnlvl_q   <= '0;
            cnt_q       <= '0;
            pcnt_q      <= '0;
            rst_req_n_q <= 1'b1;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            en_q        <= en_d;
            ien_q       <= ien_d;
            warn_q      <= warn_d;
            timeout_q   <= timeout_d;
            warnlvl_q   <= warnlvl_d;
            cnt_q       <= cnt_d;
            pcnt_q      <= pcnt_d;
            rst_req_n_q <= rst_req_n_d;
            data_out_q  <= data_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign wt        = ~phase_q;
    assign irq       = warn_q & ien_q;
    assign rst_req_n = rst_req_n_q;

endmodule

// File: tb/tb_wdt_rst_req.sv
// Bench for wdt_rst_req: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wdt_rst_req;

    localparam int          P   = 4;
    localparam int          PL  = 8;
    localparam logic [31:0] KEY = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst, stb, we;
    logic [1:0]  addr;
    logic [31:0] data_in, data_out;
    logic        wt, irq, rst_req_n;

    int checks = 0;
    int errors = 0;

    wdt_rst_req #(.PRESCALE(P), .CNT_W(16), .PULSE_LEN(PL), .KICK_KEY(KEY)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .wt(wt), .irq(irq),
        .rst_req_n(rst_req_n)
    );

    always #5 clk = ~clk;

    task automatic hchk(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: modes 0 idle, 1 run, 2 pulse, 3 hold; age = cycles since
    // the tick count last restarted.
    bit          m_valid = 0;
    int          m_mode, m_cnt, m_to, m_wl, m_age, m_left;
    bit          m_en, m_ien, m_warn, m_ph;
    logic [31:0] m_dout;

    always @(posedge clk) begin
        bit acc, wr, rd, kick, sw, tk, set_warn;
        if (rst) begin
            m_valid = 1; m_mode = 0; m_cnt = 0; m_to = 16'hFFFF; m_wl = 0;
            m_age = 0; m_left = 0; m_en = 0; m_ien = 0; m_warn = 0;
            m_ph = 0; m_dout = 0;
        end else if (m_valid) begin
            acc  = stb && m_ph;
            wr   = acc && we && (m_mode != 3);
            rd   = stb && !m_ph && !we;
            kick = wr && addr == 2 && data_in == KEY && m_mode == 1;
            sw   = wr && addr == 0 && data_in[3] && m_mode < 2;
            tk   = m_mode == 1 && !kick && (m_age % P == P - 1);
            set_warn = 0;
            if (rd) begin
                case (addr)
                    2'd0: m_dout = {29'd0, m_warn, m_ien, m_en};
                    2'd1: m_dout = 32'(m_to);
                    2'd2: m_dout = 32'(m_cnt);
                    default: m_dout = 32'(m_wl);
                endcase
            end
            if (m_mode == 2) begin
                m_left--;
                if (m_left == 0) m_mode = 3;
            end else if (sw) begin
                m_mode = 2; m_left = PL;
            end else if (m_mode == 0 && wr && addr == 0 && data_in[0]) begin
                m_mode = 1; m_cnt = m_to; m_age = 0;
            end else if (m_mode == 1) begin
                if (tk && m_cnt == 0) begin
                    m_mode = 2; m_left = PL;
                end else begin
                    if (kick) begin
                        m_cnt = m_to; m_age = 0;
                    end else begin
                        m_age++;
                        if (tk) begin
                            m_cnt--;
                            set_warn = (m_cnt == m_wl);
                        end
                    end
                    if (wr && addr == 0 && !data_in[0]) m_mode = 0;
                end
            end
            if (wr) begin
                case (addr)
                    2'd0: begin
                        m_en = data_in[0]; m_ien = data_in[1];
                        if (data_in[2]) m_warn = 0;
                    end
                    2'd1: m_to = int'(data_in[15:0]);
                    2'd3: m_wl = int'(data_in[15:0]);
                    default: ;
                endcase
            end
            if (set_warn) m_warn = 1;
            m_ph = stb && !m_ph;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            hchk("cmp_wt", 32'(wt), 32'(!m_ph));
            hchk("cmp_irq", 32'(irq), 32'(m_warn & m_ien));
            hchk("cmp_rst_req_n", 32'(rst_req_n), 32'(m_mode != 2));
            hchk("cmp_data_out", data_out, m_dout);
        end
    end

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        hchk("wr_wt_first", 32'(wt), 32'd1);
        stb = 1; we = 1; addr = a; data_in = d;
        @(negedge clk);
        hchk("wr_wt_second", 32'(wt), 32'd0);
        @(negedge clk);
        stb = 0; we = 0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] d);
        hchk("rd_wt_first", 32'(wt), 32'd1);
        stb = 1; we = 0; addr = a;
        @(negedge clk);
        hchk("rd_wt_second", 32'(wt), 32'd0);
        d = data_out;
        @(negedge clk);
        stb = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic wait_low(input int n, output bit found);
        found = 0;
        for (int k = 0; k < n && !found; k++) begin
            if (!rst_req_n) found = 1;
            else @(negedge clk);
        end
    endtask

    task automatic setup(input int to);
        do_write(2'd1, 32'(to));
        do_write(2'd3, 32'd2);
    endtask

    initial begin
        logic [31:0] r;
        int  first_irq, first_low, nlow, sawlow;
        bit  found;
        rst = 1; stb = 0; we = 0; addr = 0; data_in = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        hchk("reset_rst_req_n", 32'(rst_req_n), 32'd1);
        hchk("reset_irq", 32'(irq), 32'd0);
        hchk("reset_wt", 32'(wt), 32'd1);
        hchk("reset_data_out", data_out, 32'd0);
        do_read(2'd1, r); hchk("reset_timeout", r, 32'h0000_FFFF);
        do_read(2'd0, r); hchk("reset_ctrl", r, 32'd0);

        // Free-running expiry with warning interrupt.
        setup(5);
        do_write(2'd0, 32'h3);
        first_irq = 0; first_low = 0; nlow = 0;
        for (int k = 1; k <= 40; k++) begin
            if (irq && first_irq == 0) first_irq = k;
            if (!rst_req_n) begin
                nlow++;
                if (first_low == 0) first_low = k;
            end
            @(negedge clk);
        end
        hchk("t1_warn_cycle", 32'(first_irq), 32'd13);
        hchk("t1_low_start", 32'(first_low), 32'd25);
        hchk("t1_low_len", 32'(nlow), 32'd8);
        do_write(2'd0, 32'h8);
        hchk("hold_swrst_ignored", 32'(rst_req_n), 32'd1);
        do_write(2'd1, 32'd7);
        do_read(2'd1, r); hchk("hold_timeout_kept", r, 32'd5);

        // Regular kicks keep it alive; a bad key does not.
        do_reset();
        setup(5);
        do_write(2'd0, 32'h1);
        sawlow = 0;
        for (int i = 0; i < 60; i++) begin
            do_write(2'd2, KEY);
            repeat (13) begin
                if (!rst_req_n) sawlow++;
                @(negedge clk);
            end
        end
        hchk("t2_no_pulse", 32'(sawlow), 32'd0);
        do_write(2'd2, 32'h0);
        wait_low(40, found);
        hchk("t2_badkey_pulse", 32'(found), 32'd1);

        // Kick on the expiring tick wins.
        do_reset();
        setup(5);
        do_write(2'd0, 32'h1);
        repeat (22) @(negedge clk);
        do_write(2'd2, KEY);
        hchk("t3_kick_no_pulse", 32'(rst_req_n), 32'd1);
        do_read(2'd2, r); hchk("t3_cnt_reload", r, 32'd5);

        // Disable on the expiring tick loses.
        do_reset();
        setup(5);
        do_write(2'd0, 32'h1);
        repeat (22) @(negedge clk);
        do_write(2'd0, 32'h0);
        hchk("t3_disable_pulse", 32'(rst_req_n), 32'd0);

        // Software reset from IDLE.
        do_reset();
        do_write(2'd0, 32'h8);
        hchk("t4_swrst_low", 32'(rst_req_n), 32'd0);
        nlow = 0;
        for (int k = 0; k < 12; k++) begin
            if (!rst_req_n) nlow++;
            @(negedge clk);
        end
        hchk("t4_low_len", 32'(nlow), 32'd8);
        do_write(2'd0, 32'h1);
        do_read(2'd0, r); hchk("t4_hold_ctrl", r, 32'd0);

        // Closed loop: TIMEOUT=0, reset answered mid-pulse.
        do_reset();
        do_write(2'd1, 32'd0);
        do_write(2'd0, 32'h1);
        wait_low(20, found);
        hchk("t5_pulse_seen", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        do_reset();
        hchk("t5_abort_high", 32'(rst_req_n), 32'd1);
        do_read(2'd1, r); hchk("t5_timeout_reset", r, 32'h0000_FFFF);
        do_read(2'd0, r); hchk("t5_ctrl_reset", r, 32'd0);

        // WARN write-1-to-clear drops irq.
        do_reset();
        setup(5);
        do_write(2'd0, 32'h3);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (irq) found = 1;
            else @(negedge clk);
        end
        hchk("t6_irq_seen", 32'(found), 32'd1);
        do_write(2'd0, 32'h6);
        hchk("t6_irq_cleared", 32'(irq), 32'd0);
        do_read(2'd0, r); hchk("t6_ctrl", r, 32'd2);
        repeat (30) @(negedge clk);
        hchk("t6_idle_no_pulse", 32'(rst_req_n), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
